// File: rtl/wallace_prod_accumulator_if.sv
// Product-in / block-sum-out handshake bundle for wallace_prod_accumulator.
// The producer and result consumer share the master side.
interface wallace_prod_accumulator_if #(
  parameter int ACC_W = 12
);
  logic [7:0]       product;
  logic             prod_valid;
  logic             prod_ready;
  logic             clear;
  logic [ACC_W-1:0] acc_out;
  logic             acc_ovf;
  logic             acc_valid;
  logic             acc_ready;
  logic             busy;

  modport master (
    output product, prod_valid, clear, acc_ready,
    input  prod_ready, acc_out, acc_ovf, acc_valid, busy
  );

  modport slave (
    input  product, prod_valid, clear, acc_ready,
    output prod_ready, acc_out, acc_ovf, acc_valid, busy
  );
endinterface

// File: rtl/wallace_prod_accumulator.sv
// Sums COUNT unsigned 8-bit products into a saturating ACC_W-bit block sum,
// then holds the result until downstream consumes it.
module wallace_prod_accumulator #(
  parameter int ACC_W = 12,
  parameter int COUNT = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  wallace_prod_accumulator_if.slave   bus
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_HOLD} state_t;

  localparam logic [7:0]       COUNT_C = COUNT[7:0];
  localparam logic [ACC_W-1:0] ACC_MAX = {ACC_W{1'b1}};

  state_t           r_state, w_state_nxt;
  logic [ACC_W-1:0] r_acc, w_acc_nxt;
  logic [7:0]       r_cnt, w_cnt_nxt;
  logic             r_ovf, w_ovf_nxt;
  logic             r_valid;

  logic             w_prod_xfer;
  logic [ACC_W:0]   w_sum;
  logic [7:0]       w_cnt_inc;

  // prod_ready is a pure state decode, so the transfer needs no path back to prod_valid
  assign w_prod_xfer = bus.prod_valid && (r_state != S_HOLD);
  assign w_sum       = {1'b0, r_acc} + {{(ACC_W-7){1'b0}}, bus.product};
  assign w_cnt_inc   = r_cnt + 8'd1;

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_ovf_nxt   = r_ovf;
    if (bus.clear) begin
      w_state_nxt = S_IDLE;
      w_acc_nxt   = '0;
      w_cnt_nxt   = '0;
      w_ovf_nxt   = 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_prod_xfer) begin
            w_acc_nxt   = {{(ACC_W-8){1'b0}}, bus.product};
            w_cnt_nxt   = 8'd1;
            w_ovf_nxt   = 1'b0;
            w_state_nxt = (COUNT == 1) ? S_HOLD : S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (w_prod_xfer) begin
            w_acc_nxt = w_sum[ACC_W] ? ACC_MAX : w_sum[ACC_W-1:0];
            w_ovf_nxt = r_ovf | w_sum[ACC_W];
            w_cnt_nxt = w_cnt_inc;
            if (w_cnt_inc == COUNT_C) w_state_nxt = S_HOLD;
          end
        end
        S_HOLD: begin
          if (bus.acc_ready) begin
            w_state_nxt = S_IDLE;
            w_acc_nxt   = '0;
            w_cnt_nxt   = '0;
            w_ovf_nxt   = 1'b0;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_acc_nxt   = '0;
          w_cnt_nxt   = '0;
          w_ovf_nxt   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ovf   <= w_ovf_nxt;
      r_valid <= (w_state_nxt == S_HOLD);
    end
  end

  assign bus.prod_ready = (r_state != S_HOLD);
  assign bus.acc_out    = r_acc;
  assign bus.acc_ovf    = r_ovf;
  assign bus.acc_valid  = r_valid;
  assign bus.busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_wallace_prod_accumulator.sv
// Three accumulator configurations share one directed stimulus stream and are
// checked every cycle against a block-sum model, plus literal spot checks.
module tb_wallace_prod_accumulator;

  localparam int NI = 3;
  localparam int AW [NI] = '{12, 9, 12};
  localparam int CN [NI] = '{4, 4, 1};

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] product = '0;
  logic       prod_valid = 1'b0;
  logic       clear = 1'b0;
  logic       acc_ready = 1'b1;
  bit         chk_en = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  wallace_prod_accumulator_if #(.ACC_W(12)) u_if0 ();
  wallace_prod_accumulator_if #(.ACC_W(9))  u_if1 ();
  wallace_prod_accumulator_if #(.ACC_W(12)) u_if2 ();

  assign u_if0.product = product;  assign u_if0.prod_valid = prod_valid;
  assign u_if0.clear   = clear;    assign u_if0.acc_ready  = acc_ready;
  assign u_if1.product = product;  assign u_if1.prod_valid = prod_valid;
  assign u_if1.clear   = clear;    assign u_if1.acc_ready  = acc_ready;
  assign u_if2.product = product;  assign u_if2.prod_valid = prod_valid;
  assign u_if2.clear   = clear;    assign u_if2.acc_ready  = acc_ready;

  wallace_prod_accumulator #(.ACC_W(12), .COUNT(4)) u_def (.clk(clk), .rst_n(rst_n), .bus(u_if0));
  wallace_prod_accumulator #(.ACC_W(9),  .COUNT(4)) u_sat (.clk(clk), .rst_n(rst_n), .bus(u_if1));
  wallace_prod_accumulator #(.ACC_W(12), .COUNT(1)) u_c1  (.clk(clk), .rst_n(rst_n), .bus(u_if2));

  logic [31:0] g_acc  [NI];
  logic        g_ovf  [NI];
  logic        g_vld  [NI];
  logic        g_rdy  [NI];
  logic        g_busy [NI];

  assign g_acc[0] = 32'(u_if0.acc_out); assign g_ovf[0] = u_if0.acc_ovf; assign g_vld[0] = u_if0.acc_valid;
  assign g_rdy[0] = u_if0.prod_ready;   assign g_busy[0] = u_if0.busy;
  assign g_acc[1] = 32'(u_if1.acc_out); assign g_ovf[1] = u_if1.acc_ovf; assign g_vld[1] = u_if1.acc_valid;
  assign g_rdy[1] = u_if1.prod_ready;   assign g_busy[1] = u_if1.busy;
  assign g_acc[2] = 32'(u_if2.acc_out); assign g_ovf[2] = u_if2.acc_ovf; assign g_vld[2] = u_if2.acc_valid;
  assign g_rdy[2] = u_if2.prod_ready;   assign g_busy[2] = u_if2.busy;

  // Model: unbounded block sum and product count; saturation falls out as min().
  longint m_sum  [NI] = '{0, 0, 0};
  int     m_n    [NI] = '{0, 0, 0};
  bit     m_hold [NI] = '{0, 0, 0};

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < NI; k++) begin
      if (!rst_n || clear) begin
        m_sum[k] <= 0; m_n[k] <= 0; m_hold[k] <= 1'b0;
      end else if (m_hold[k]) begin
        if (acc_ready) begin
          m_sum[k] <= 0; m_n[k] <= 0; m_hold[k] <= 1'b0;
        end
      end else if (prod_valid) begin
        m_sum[k] <= m_sum[k] + longint'(product);
        m_n[k]   <= m_n[k] + 1;
        if (m_n[k] + 1 == CN[k]) m_hold[k] <= 1'b1;
      end
    end
  end

  task automatic chk(input string nm, input int k, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d got %0d expected %0d at %0t", nm, k, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < NI; k++) begin
        longint mx;
        mx = (longint'(1) << AW[k]) - 1;
        chk("acc_out",    k, longint'(g_acc[k]), (m_sum[k] > mx) ? mx : m_sum[k]);
        chk("acc_ovf",    k, longint'(g_ovf[k]), longint'(m_sum[k] > mx));
        chk("acc_valid",  k, longint'(g_vld[k]), longint'(m_hold[k]));
        chk("prod_ready", k, longint'(g_rdy[k]), longint'(!m_hold[k]));
        chk("busy",       k, longint'(g_busy[k]), longint'(m_hold[k] || m_n[k] != 0));
      end
    end
  end

  task automatic drive(input logic [7:0] p);
    @(negedge clk);
    product = p;
    prod_valid = 1'b1;
  endtask

  task automatic sync_clear();
    @(negedge clk);
    clear = 1'b1;
    prod_valid = 1'b0;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("lit_rst_acc", 0, longint'(g_acc[0]), 0);
    chk("lit_rst_vld", 0, longint'(g_vld[0]), 0);
    chk("lit_rst_busy", 0, longint'(g_busy[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Normal block of 225s
    sync_clear();
    acc_ready = 1'b1;
    repeat (4) drive(8'd225);
    @(negedge clk);
    prod_valid = 1'b0;
    chk("lit_norm_acc", 0, longint'(g_acc[0]), 900);
    chk("lit_norm_vld", 0, longint'(g_vld[0]), 1);
    chk("lit_norm_ovf", 0, longint'(g_ovf[0]), 0);
    chk("lit_norm_rdy", 0, longint'(g_rdy[0]), 0);
    @(negedge clk);
    chk("lit_norm_rdy2", 0, longint'(g_rdy[0]), 1);

    // Saturation on the 9-bit instance
    sync_clear();
    repeat (3) drive(8'd225);
    @(negedge clk);
    chk("lit_sat3_acc", 1, longint'(g_acc[1]), 511);
    chk("lit_sat3_ovf", 1, longint'(g_ovf[1]), 1);
    product = 8'd10;
    @(negedge clk);
    prod_valid = 1'b0;
    chk("lit_sat4_acc", 1, longint'(g_acc[1]), 511);
    chk("lit_sat4_ovf", 1, longint'(g_ovf[1]), 1);
    chk("lit_sat4_vld", 1, longint'(g_vld[1]), 1);
    @(negedge clk);
    chk("lit_sat_next_ovf", 1, longint'(g_ovf[1]), 0);
    drive(8'd1);
    @(negedge clk);
    prod_valid = 1'b0;
    chk("lit_sat_new_acc", 1, longint'(g_acc[1]), 1);
    chk("lit_sat_new_ovf", 1, longint'(g_ovf[1]), 0);

    // Backpressure
    sync_clear();
    acc_ready = 1'b0;
    drive(8'd1); drive(8'd2); drive(8'd3); drive(8'd4);
    @(negedge clk);
    product = 8'd7;
    for (int i = 0; i < 6; i++) begin
      chk("lit_bp_rdy", 0, longint'(g_rdy[0]), 0);
      chk("lit_bp_acc", 0, longint'(g_acc[0]), 10);
      @(negedge clk);
    end
    acc_ready = 1'b1;
    @(negedge clk);
    chk("lit_bp_xfer_vld", 0, longint'(g_vld[0]), 0);
    @(negedge clk);
    prod_valid = 1'b0;
    chk("lit_bp_first", 0, longint'(g_acc[0]), 7);
    chk("lit_bp_busy", 0, longint'(g_busy[0]), 1);

    // Clear mid-block beats a simultaneous product transfer
    sync_clear();
    drive(8'd50); drive(8'd60);
    @(negedge clk);
    clear = 1'b1;
    product = 8'd70;
    @(negedge clk);
    clear = 1'b0;
    prod_valid = 1'b0;
    chk("lit_clr_acc", 0, longint'(g_acc[0]), 0);
    chk("lit_clr_busy", 0, longint'(g_busy[0]), 0);
    repeat (4) drive(8'd1);
    @(negedge clk);
    prod_valid = 1'b0;
    chk("lit_clr_blk_acc", 0, longint'(g_acc[0]), 4);
    chk("lit_clr_blk_vld", 0, longint'(g_vld[0]), 1);

    // Asynchronous reset while holding
    sync_clear();
    acc_ready = 1'b0;
    repeat (4) drive(8'd225);
    @(negedge clk);
    prod_valid = 1'b0;
    chk("lit_ar_pre_acc", 0, longint'(g_acc[0]), 900);
    #2 rst_n = 1'b0;
    #1;
    chk("lit_ar_vld", 0, longint'(g_vld[0]), 0);
    chk("lit_ar_acc", 0, longint'(g_acc[0]), 0);
    chk("lit_ar_busy", 0, longint'(g_busy[0]), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    acc_ready = 1'b1;

    // COUNT=1 throughput
    sync_clear();
    @(negedge clk);
    product = 8'd5;
    prod_valid = 1'b1;
    @(negedge clk);
    chk("lit_c1_acc", 2, longint'(g_acc[2]), 5);
    chk("lit_c1_vld", 2, longint'(g_vld[2]), 1);
    chk("lit_c1_rdy", 2, longint'(g_rdy[2]), 0);
    product = 8'd6;
    @(negedge clk);
    chk("lit_c1_xfer_vld", 2, longint'(g_vld[2]), 0);
    chk("lit_c1_xfer_busy", 2, longint'(g_busy[2]), 0);
    product = 8'd9;
    @(negedge clk);
    prod_valid = 1'b0;
    chk("lit_c1_acc2", 2, longint'(g_acc[2]), 9);
    chk("lit_c1_vld2", 2, longint'(g_vld[2]), 1);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
